// File: rtl/axi4_lite_req_arbiter_if.sv
// Requester and AXI4-Lite master command/response signals of the request arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface axi4_lite_req_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_write;
    logic [NUM_REQ*32-1:0] req_addr;
    logic [NUM_REQ*32-1:0] req_wdata;
    logic [NUM_REQ*4-1:0]  req_wstrb;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [31:0]           rsp_rdata;
    logic [1:0]            rsp_resp;

    logic                  write_req;
    logic [31:0]           write_addr;
    logic [31:0]           write_data;
    logic [3:0]            write_strb;
    logic                  write_done;
    logic [1:0]            write_resp;
    logic                  read_req;
    logic [31:0]           read_addr;
    logic                  read_done;
    logic [31:0]           read_data;
    logic [1:0]            read_resp;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_wstrb,
        input  write_done, write_resp, read_done, read_data, read_resp,
        output req_ready, rsp_valid, rsp_rdata, rsp_resp,
        output write_req, write_addr, write_data, write_strb, read_req, read_addr
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_wstrb,
        output write_done, write_resp, read_done, read_data, read_resp,
        input  req_ready, rsp_valid, rsp_rdata, rsp_resp,
        input  write_req, write_addr, write_data, write_strb, read_req, read_addr
    );
endinterface

// File: rtl/axi4_lite_req_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite master command port among NUM_REQ requesters.
// Exactly one transaction is outstanding at a time; the response is routed to the granted requester.
module axi4_lite_req_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                   aclk,
    input  logic                   rst_n,
    axi4_lite_req_arbiter_if.slave bus,
    output logic                   busy,
    output logic [ID_W-1:0]        grant_id,
    output logic [15:0]            txn_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_WR,
        WAIT_RD
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] sel_idx;
    logic            sel_found;
    logic [ID_W:0]   idx_w;
    logic [ID_W-1:0] idx;
    logic            accept;
    logic            complete;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    logic [3:0]      wstrb_q;

    // Rotating priority search; idx_w carries one spare bit so the wrap works for non-power-of-two NUM_REQ.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        idx_w     = '0;
        idx       = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            idx_w = {1'b0, rr_ptr} + (ID_W+1)'(j);
            if (idx_w >= (ID_W+1)'(NUM_REQ)) begin
                idx_w = idx_w - (ID_W+1)'(NUM_REQ);
            end
            idx = idx_w[ID_W-1:0];
            if (!sel_found && bus.req_valid[idx]) begin
                sel_found = 1'b1;
                sel_idx   = idx;
            end
        end
    end

    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        accept        = 1'b0;
        complete      = 1'b0;
        bus.req_ready = '0;
        unique case (state)
            IDLE: begin
                if (sel_found && rst_n) begin
                    accept                 = 1'b1;
                    bus.req_ready[sel_idx] = 1'b1;
                    state_nxt              = bus.req_write[sel_idx] ? WAIT_WR : WAIT_RD;
                end
            end
            WAIT_WR: begin
                if (bus.write_done) begin
                    complete  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            WAIT_RD: begin
                if (bus.read_done) begin
                    complete  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr        <= '0;
            grant_id      <= '0;
            txn_cnt       <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            bus.write_req <= 1'b0;
            bus.read_req  <= 1'b0;
            bus.rsp_valid <= '0;
            bus.rsp_rdata <= '0;
            bus.rsp_resp  <= '0;
        end else begin
            bus.write_req <= 1'b0;
            bus.read_req  <= 1'b0;
            bus.rsp_valid <= '0;
            if (accept) begin
                grant_id      <= sel_idx;
                addr_q        <= bus.req_addr[{sel_idx, 5'b0} +: 32];
                wdata_q       <= bus.req_wdata[{sel_idx, 5'b0} +: 32];
                wstrb_q       <= bus.req_wstrb[{sel_idx, 2'b0} +: 4];
                bus.write_req <= bus.req_write[sel_idx];
                bus.read_req  <= !bus.req_write[sel_idx];
            end
            if (complete) begin
                bus.rsp_valid[grant_id] <= 1'b1;
                bus.rsp_resp  <= (state == WAIT_WR) ? bus.write_resp : bus.read_resp;
                bus.rsp_rdata <= (state == WAIT_WR) ? 32'h0 : bus.read_data;
                rr_ptr        <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
                txn_cnt       <= txn_cnt + 16'd1;
            end
        end
    end

    assign busy           = (state != IDLE);
    assign bus.write_addr = addr_q;
    assign bus.read_addr  = addr_q;
    assign bus.write_data = wdata_q;
    assign bus.write_strb = wstrb_q;

endmodule

// File: tb/tb_axi4_lite_req_arbiter.sv
// Directed bench for axi4_lite_req_arbiter: inputs driven and outputs sampled on the falling edge.
module tb_axi4_lite_req_arbiter;

    localparam int NUM_REQ = 4;

    logic        aclk = 1'b0;
    logic        rst_n;
    logic        busy;
    logic [1:0]  grant_id;
    logic [15:0] txn_cnt;
    int unsigned checks = 0;
    int unsigned errors = 0;

    axi4_lite_req_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    axi4_lite_req_arbiter #(.NUM_REQ(NUM_REQ)) dut (
        .aclk     (aclk),
        .rst_n    (rst_n),
        .bus      (bus),
        .busy     (busy),
        .grant_id (grant_id),
        .txn_cnt  (txn_cnt)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] oh(input int unsigned i);
        oh    = '0;
        oh[i] = 1'b1;
    endfunction

    task automatic step();
        @(negedge aclk);
    endtask

    task automatic set_req(input int unsigned i, input logic wr, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s);
        bus.req_valid[i]         = 1'b1;
        bus.req_write[i]         = wr;
        bus.req_addr[32*i +: 32] = a;
        bus.req_wdata[32*i +: 32] = d;
        bus.req_wstrb[4*i +: 4]  = s;
    endtask

    task automatic clr_req(input int unsigned i);
        bus.req_valid[i] = 1'b0;
    endtask

    // Called on a falling edge; returns on the falling edge where rsp_valid is visible.
    task automatic pulse_done(input logic wr, input logic [1:0] resp, input logic [31:0] rdata);
        if (wr) begin
            bus.write_done = 1'b1;
            bus.write_resp = resp;
        end else begin
            bus.read_done = 1'b1;
            bus.read_resp = resp;
            bus.read_data = rdata;
        end
        step();
        bus.write_done = 1'b0;
        bus.read_done  = 1'b0;
        #1;
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.req_valid  = '0;
        bus.req_write  = '0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.req_wstrb  = '0;
        bus.write_done = 1'b0;
        bus.write_resp = '0;
        bus.read_done  = 1'b0;
        bus.read_data  = '0;
        bus.read_resp  = '0;

        // Reset state, with a request already pending
        repeat (3) step();
        set_req(1, 1'b1, 32'h10, 32'hA5A5_0001, 4'hF);
        #1;
        check("rst_ready", bus.req_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_txn", txn_cnt, 0);
        check("rst_grant", grant_id, 0);
        check("rst_wreq", bus.write_req, 0);
        check("rst_rsp", bus.rsp_valid, 0);
        check("rst_waddr", bus.write_addr, 0);

        // 1: single write from requester 1
        step();
        rst_n = 1'b1;
        #1;
        check("t1_ready", bus.req_ready, 4'b0010);
        step();
        clr_req(1);
        #1;
        check("t1_wreq", bus.write_req, 1);
        check("t1_rreq", bus.read_req, 0);
        check("t1_waddr", bus.write_addr, 32'h10);
        check("t1_wdata", bus.write_data, 32'hA5A5_0001);
        check("t1_wstrb", bus.write_strb, 4'hF);
        check("t1_grant", grant_id, 1);
        check("t1_busy", busy, 1);
        check("t1_ready_wait", bus.req_ready, 0);
        step();
        #1;
        check("t1_wreq_end", bus.write_req, 0);
        check("t1_waddr_hold", bus.write_addr, 32'h10);
        pulse_done(1'b1, 2'b00, 32'h0);
        check("t1_rsp", bus.rsp_valid, 4'b0010);
        check("t1_resp", bus.rsp_resp, 0);
        check("t1_rdata", bus.rsp_rdata, 0);
        check("t1_idle", busy, 0);
        check("t1_txn", txn_cnt, 1);
        step();
        #1;
        check("t1_rsp_end", bus.rsp_valid, 0);

        // 2: single read from requester 2
        set_req(2, 1'b0, 32'h20, 32'h0, 4'h0);
        #1;
        check("t2_ready", bus.req_ready, 4'b0100);
        step();
        clr_req(2);
        #1;
        check("t2_rreq", bus.read_req, 1);
        check("t2_wreq", bus.write_req, 0);
        check("t2_raddr", bus.read_addr, 32'h20);
        check("t2_grant", grant_id, 2);
        step();
        #1;
        check("t2_rreq_end", bus.read_req, 0);
        pulse_done(1'b0, 2'b00, 32'hDEAD_BEEF);
        check("t2_rsp", bus.rsp_valid, 4'b0100);
        check("t2_rdata", bus.rsp_rdata, 32'hDEAD_BEEF);
        check("t2_resp", bus.rsp_resp, 0);
        check("t2_txn", txn_cnt, 2);

        // 4: error response, spurious read_done while waiting on a write
        step();
        set_req(0, 1'b1, 32'h40, 32'h1234_5678, 4'h3);
        #1;
        check("t4_ready", bus.req_ready, 4'b0001);
        step();
        clr_req(0);
        #1;
        check("t4_wstrb", bus.write_strb, 4'h3);
        check("t4_wdata", bus.write_data, 32'h1234_5678);
        pulse_done(1'b0, 2'b00, 32'hFFFF_FFFF);
        check("t4_spur_rsp", bus.rsp_valid, 0);
        check("t4_spur_busy", busy, 1);
        pulse_done(1'b1, 2'b10, 32'h0);
        check("t4_rsp", bus.rsp_valid, 4'b0001);
        check("t4_resp", bus.rsp_resp, 2'b10);
        check("t4_txn", txn_cnt, 3);

        // Request withdrawn before the edge, and a done pulse while idle
        step();
        set_req(2, 1'b1, 32'h50, 32'h0, 4'hF);
        #1;
        clr_req(2);
        step();
        #1;
        check("wd_busy", busy, 0);
        pulse_done(1'b1, 2'b00, 32'h0);
        check("idle_done_rsp", bus.rsp_valid, 0);
        check("idle_done_txn", txn_cnt, 3);

        // 5: reset while waiting on a read
        step();
        set_req(3, 1'b0, 32'h30, 32'h0, 4'h0);
        #1;
        check("t5_ready", bus.req_ready, 4'b1000);
        step();
        clr_req(3);
        step();
        rst_n = 1'b0;
        #1;
        check("t5_busy", busy, 0);
        check("t5_rreq", bus.read_req, 0);
        check("t5_txn", txn_cnt, 0);
        pulse_done(1'b0, 2'b00, 32'h1111_1111);
        check("t5_rsp", bus.rsp_valid, 0);
        rst_n = 1'b1;

        // 3: all four requesters valid continuously, grant order 0,1,2,3,0
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            set_req(i, 1'b1, 32'h100 + i, 32'h200 + i, 4'hF);
        end
        for (int unsigned k = 0; k < 5; k++) begin
            #1;
            check("t3_ready", bus.req_ready, oh(k % 4));
            step();
            #1;
            check("t3_grant", grant_id, k % 4);
            check("t3_waddr", bus.write_addr, 32'h100 + (k % 4));
            check("t3_ready_wait", bus.req_ready, 0);
            pulse_done(1'b1, 2'b00, 32'h0);
            check("t3_rsp", bus.rsp_valid, oh(k % 4));
            bus.req_valid = '0;
            if (k < 4) begin
                bus.req_valid = '1;
            end
        end
        check("t3_txn", txn_cnt, 5);

        // 6: completion counter wrap
        step();
        force dut.txn_cnt = 16'hFFFF;
        step();
        release dut.txn_cnt;
        #1;
        check("t6_pre", txn_cnt, 16'hFFFF);
        set_req(0, 1'b1, 32'h60, 32'h6, 4'h1);
        step();
        clr_req(0);
        pulse_done(1'b1, 2'b00, 32'h0);
        check("t6_rsp", bus.rsp_valid, 4'b0001);
        check("t6_wrap", txn_cnt, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
